// File: rtl/data_memory_dump_controller.sv
// Data-memory arbiter: passes MEM-stage accesses through while idle, and when the
// pipeline is halted streams every memory word out over a valid/ready handshake.
module data_memory_dump_controller #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 2**NB_ADDR
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [NB_ADDR-1:0] i_pipe_addr,
    input  logic [NB_DATA-1:0] i_pipe_wr_data,
    input  logic               i_pipe_wr_enable,
    input  logic               i_pipe_rd_enable,
    output logic [NB_DATA-1:0] o_pipe_rd_data,
    output logic               o_pipe_stall,
    input  logic               i_halted,
    input  logic               i_dump_start,
    output logic               o_dump_busy,
    output logic               o_dump_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wr_data,
    output logic               o_mem_wr_enable,
    output logic               o_mem_rd_enable,
    input  logic [NB_DATA-1:0] i_mem_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] PTR_LAST = '1;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] ptr_q, ptr_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (i_dump_start && i_halted) begin
                    state_d = S_READ;
                    ptr_d   = '0;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                tx_data_d = i_mem_rd_data;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // All status outputs decode the state register only, so the stall is glitch-free.
    always_comb begin
        o_dump_busy  = (state_q != S_IDLE);
        o_pipe_stall = (state_q != S_IDLE);
        o_dump_done  = (state_q == S_DONE);
        o_tx_valid   = (state_q == S_SEND);
        o_tx_data    = tx_data_q;
        if (state_q == S_IDLE) begin
            o_mem_addr      = i_pipe_addr;
            o_mem_wr_data   = i_pipe_wr_data;
            o_mem_wr_enable = i_pipe_wr_enable;
            o_mem_rd_enable = i_pipe_rd_enable;
        end else begin
            o_mem_addr      = ptr_q;
            o_mem_wr_data   = '0;
            o_mem_wr_enable = 1'b0;
            o_mem_rd_enable = (state_q == S_READ);
        end
    end

    assign o_pipe_rd_data = i_mem_rd_data;

endmodule

// File: tb/tb_data_memory_dump_controller.sv
// Bench: behavioural data memory behind the DUT, scoreboard of expected dump words.
module tb_data_memory_dump_controller;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wr_data;
    logic          pipe_wr_en, pipe_rd_en;
    logic [DW-1:0] pipe_rd_data;
    logic          pipe_stall;
    logic          halted, dump_start;
    logic          dump_busy, dump_done;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_en, mem_rd_en;
    logic [DW-1:0] mem_rd_data;

    logic [DW-1:0] mem [DEPTH];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          first_valid_cyc = -1;
    int          done_cyc = -1;
    int          s;
    logic [DW-1:0] exp_q [$];

    data_memory_dump_controller #(.NB_ADDR(AW), .NB_DATA(DW)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_pipe_addr      (pipe_addr),
        .i_pipe_wr_data   (pipe_wr_data),
        .i_pipe_wr_enable (pipe_wr_en),
        .i_pipe_rd_enable (pipe_rd_en),
        .o_pipe_rd_data   (pipe_rd_data),
        .o_pipe_stall     (pipe_stall),
        .i_halted         (halted),
        .i_dump_start     (dump_start),
        .o_dump_busy      (dump_busy),
        .o_dump_done      (dump_done),
        .o_tx_data        (tx_data),
        .o_tx_valid       (tx_valid),
        .i_tx_ready       (tx_ready),
        .o_mem_addr       (mem_addr),
        .o_mem_wr_data    (mem_wr_data),
        .o_mem_wr_enable  (mem_wr_en),
        .o_mem_rd_enable  (mem_rd_en),
        .i_mem_rd_data    (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: handshakes are observed mid-cycle and accepted at the following edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) check_eq("tx_unexpected", 32'd1, 32'd0);
                else check_eq("tx_data", tx_data, exp_q.pop_front());
            end
            if (dump_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dump_busy) begin
                check_eq("gate_wr", {31'd0, mem_wr_en}, 32'd0);
                check_eq("stall_busy", {31'd0, pipe_stall}, 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        for (int unsigned k = 0; k < DEPTH; k++) exp_q.push_back(DW'(k * 3));
    endtask

    task automatic pulse_start();
        step();
        dump_start = 1'b1;
        s = cyc;
        step();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!dump_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check_eq("done_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check_eq("hs_timeout", DW'(hs_cnt), DW'(target));
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_addr = 5'd3; pipe_wr_data = '0; pipe_wr_en = 1'b0; pipe_rd_en = 1'b0;
        halted = 1'b0; dump_start = 1'b0; tx_ready = 1'b0;
        #12;
        check_eq("rst_busy",  {31'd0, dump_busy},  32'd0);
        check_eq("rst_valid", {31'd0, tx_valid},   32'd0);
        check_eq("rst_stall", {31'd0, pipe_stall}, 32'd0);
        check_eq("rst_done",  {31'd0, dump_done},  32'd0);
        check_eq("rst_txdata", tx_data, 32'd0);
        check_eq("rst_addr_pass", {27'd0, mem_addr}, 32'd3);
        rst_n = 1'b1;

        // Passthrough store then load
        step();
        pipe_addr = 5'd7; pipe_wr_data = 32'hDEADBEEF; pipe_wr_en = 1'b1;
        #1 check_eq("pass_wr_en", {31'd0, mem_wr_en}, 32'd1);
        check_eq("pass_wr_data", mem_wr_data, 32'hDEADBEEF);
        step();
        pipe_wr_en = 1'b0; pipe_rd_en = 1'b1;
        #1 check_eq("pass_rd_en", {31'd0, mem_rd_en}, 32'd1);
        step();
        pipe_rd_en = 1'b0;
        check_eq("pass_rd_data", pipe_rd_data, 32'hDEADBEEF);
        check_eq("pass_stall", {31'd0, pipe_stall}, 32'd0);

        // Preload through the passthrough path
        for (int unsigned k = 0; k < DEPTH; k++) begin
            pipe_addr = AW'(k); pipe_wr_data = DW'(k * 3); pipe_wr_en = 1'b1;
            step();
        end
        pipe_wr_en = 1'b0;

        // Start without halt is ignored
        tx_ready = 1'b1;
        pulse_start();
        step();
        check_eq("nohalt_busy", {31'd0, dump_busy}, 32'd0);
        repeat (4) step();

        // Full dump, ready high, second start and a gated store mid-dump
        halted = 1'b1;
        push_dump();
        hs_cnt = 0; done_cnt = 0; first_valid_cyc = -1; done_cyc = -1;
        pulse_start();
        wait_hs(4, 50);
        dump_start = 1'b1;
        pipe_addr = 5'd2; pipe_wr_data = 32'hFFFFFFFF; pipe_wr_en = 1'b1;
        halted = 1'b0;
        step();
        dump_start = 1'b0;
        repeat (5) step();
        pipe_wr_en = 1'b0;
        wait_done(200);
        check_eq("first_valid_lat", DW'(first_valid_cyc - s), 32'd3);
        check_eq("done_lat", DW'(done_cyc - s), 32'd97);
        step();
        check_eq("dump1_words", DW'(hs_cnt), DW'(DEPTH));
        check_eq("dump1_done_cnt", DW'(done_cnt), 32'd1);
        check_eq("dump1_idle", {31'd0, dump_busy}, 32'd0);
        check_eq("mem2_kept", mem[2], 32'd6);
        check_eq("dump1_q_empty", DW'(exp_q.size()), 32'd0);

        // Backpressure on word 5
        halted = 1'b1;
        push_dump();
        hs_cnt = 0; done_cnt = 0;
        pulse_start();
        wait_hs(5, 50);
        step();
        tx_ready = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'd0, tx_valid}, 32'd1);
            check_eq("bp_data", tx_data, 32'd15);
            check_eq("bp_ptr", {27'd0, mem_addr}, 32'd5);
        end
        check_eq("bp_hs_held", DW'(hs_cnt), 32'd5);
        step();
        tx_ready = 1'b1;
        wait_done(200);
        step();
        check_eq("dump2_words", DW'(hs_cnt), DW'(DEPTH));
        check_eq("dump2_done_cnt", DW'(done_cnt), 32'd1);

        // Reset mid-dump, then a fresh dump from address 0
        push_dump();
        hs_cnt = 0;
        pulse_start();
        wait_hs(11, 60);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid_valid", {31'd0, tx_valid},   32'd0);
        check_eq("rstmid_busy",  {31'd0, dump_busy},  32'd0);
        check_eq("rstmid_stall", {31'd0, pipe_stall}, 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        check_eq("rstmid_idle", {31'd0, dump_busy}, 32'd0);
        push_dump();
        hs_cnt = 0; done_cnt = 0;
        pulse_start();
        wait_done(200);
        step();
        check_eq("dump3_words", DW'(hs_cnt), DW'(DEPTH));
        check_eq("dump3_done_cnt", DW'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/data_memory_dump_controller.md
# data_memory_dump_controller

Sequencer and arbiter for the data memory behind the memory-access stage. In normal operation it passes the pipeline's MEM-stage accesses straight through to the data memory. When the pipeline is halted and the debug unit requests a dump, it takes ownership of the memory and reads every word in address order. Each word is streamed to the debug unit over a valid/ready handshake.

## Interface
Parameters:
- NB_ADDR, 5, data memory address width; memory depth is 2**NB_ADDR words
- NB_DATA, 2**NB_ADDR, data word width

Ports:
- i_clock  in  1  system clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_pipe_addr  in  NB_ADDR  MEM-stage address
- i_pipe_wr_data  in  NB_DATA  MEM-stage store data
- i_pipe_wr_enable  in  1  MEM-stage store request
- i_pipe_rd_enable  in  1  MEM-stage load request
- o_pipe_rd_data  out  NB_DATA  load data returned to the MEM stage (i_mem_rd_data passthrough)
- o_pipe_stall  out  1  high while the controller owns the memory
- i_halted  in  1  pipeline halted by the debug unit
- i_dump_start  in  1  dump request, sampled each cycle
- o_dump_busy  out  1  dump in progress
- o_dump_done  out  1  one-cycle pulse after the last word is accepted
- o_tx_data  out  NB_DATA  dumped word
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  debug unit accepts o_tx_data
- o_mem_addr  out  NB_ADDR  data memory address
- o_mem_wr_data  out  NB_DATA  data memory write data
- o_mem_wr_enable  out  1  data memory write enable
- o_mem_rd_enable  out  1  data memory read enable
- i_mem_rd_data  in  NB_DATA  data memory read data, valid one cycle after o_mem_rd_enable

## Operation
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- **IDLE**
  - Memory ports are combinationally driven from the i_pipe_* inputs.
  - o_pipe_stall = 0.
  - Transition to READ when i_dump_start && i_halted; clear the address pointer ptr to 0.
- **READ**
  - o_mem_addr = ptr, o_mem_rd_enable = 1, o_mem_wr_enable = 0.
  - Always transition to WAIT.
- **WAIT**
  - Register i_mem_rd_data into the tx data register.
  - Always transition to SEND.
- **SEND**
  - o_tx_valid = 1; o_tx_data is held stable until the handshake.
  - On i_tx_valid && i_tx_ready (i.e. o_tx_valid && i_tx_ready):
    - if ptr == 2**NB_ADDR-1, go to DONE;
    - else increment ptr and go to READ.
- **DONE**
  - o_dump_done = 1 for this single cycle, then go to IDLE.
- **Outside IDLE**
  - o_dump_busy = 1 and o_pipe_stall = 1.
  - Pipeline enables are gated off: a pipeline store never reaches memory during a dump.
- **ptr arithmetic**
  - NB_ADDR-bit unsigned.
  - Never wraps within a dump; exactly 2**NB_ADDR words are sent per dump.
- **Boundary conditions**
  - i_dump_start with i_halted = 0: ignored; stay in IDLE.
  - i_dump_start outside IDLE (including in DONE): ignored; no restart.
  - i_halted falling mid-dump: the dump completes; the stall holds the pipeline until IDLE.
  - i_tx_ready held low: stay in SEND indefinitely with data and valid held stable; no timeout.
  - i_tx_ready high outside SEND: no effect.
  - Reset mid-dump: immediately go to IDLE with ptr = 0 and all outputs at their reset values; no partial dump resumes.

## Timing
- **Reset values**
  - FSM = IDLE, ptr = 0.
  - o_tx_data = 0, o_tx_valid = 0.
  - o_dump_busy = 0, o_dump_done = 0, o_pipe_stall = 0.
  - Memory outputs follow the i_pipe_* inputs.
- **Dump latency**
  - i_dump_start sampled at edge 0.
  - READ in cycle 1, WAIT in cycle 2, first o_tx_valid in cycle 3.
- **Throughput with i_tx_ready held high**
  - 3 cycles per word.
  - Full dump at default parameters: 96 cycles, then o_dump_done in cycle 97, IDLE in cycle 98.
- **Passthrough**
  - In IDLE the pipeline path is purely combinational: zero added latency.
  - o_pipe_stall is registered-state derived (decoded from the FSM state register), glitch-free.

## Test plan
- **Passthrough:** in IDLE, pipeline store 0xDEADBEEF to addr 7, then load addr 7 → the load returns 0xDEADBEEF one cycle later; o_pipe_stall stays 0.
- **Full dump:** preload mem[k] = k*3, i_halted = 1, pulse i_dump_start, i_tx_ready = 1 →
  - 32 handshakes carrying 0, 3, …, 93 in order;
  - first o_tx_valid 3 cycles after start;
  - o_dump_done pulses once, 97 cycles after start.
- **Backpressure:** i_tx_ready = 0 for 10 cycles on word 5 → o_tx_valid and o_tx_data = 15 held stable throughout; no ptr advance; the dump resumes when ready returns.
- **Start without halt, or while busy:** pulse i_dump_start with i_halted = 0 → o_dump_busy stays 0; a second pulse mid-dump → the word sequence is unchanged and only one o_dump_done pulse occurs.
- **Stall gating:** assert i_pipe_wr_enable to addr 2 with data 0xFFFFFFFF during a dump → mem[2] is unchanged and o_mem_wr_enable = 0 throughout.
- **Reset mid-dump:** assert i_reset_n = 0 during word 10 → o_tx_valid, o_dump_busy and o_pipe_stall drop asynchronously; a new dump after release starts from address 0.
